// File: rtl/sdft_comb.sv
// Sliding-DFT comb front-end: y[n] = x[n] - x[n-N] over the last N accepted samples.
// Two register stages: delay-line read plus input capture, then the exact DW+1 bit difference.
module sdft_comb #(
  parameter int unsigned DW = 16,
  parameter int unsigned N  = 256
) (
  input  logic          clk_i,
  input  logic          srst_i,
  input  logic [DW-1:0] data_i,
  input  logic          valid_i,
  input  logic          clear_i,
  output logic [DW:0]   data_o,
  output logic          valid_o,
  output logic          full_o
);

  localparam int unsigned PW = $clog2(N);
  localparam int unsigned CW = $clog2(N + 1);

  logic [DW-1:0] mem [N];

  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;

  logic          v1_q;
  logic [DW-1:0] in1_q;
  logic [DW-1:0] old1_q;
  logic          real1_q;

  logic [DW:0]   data_q;
  logic          valid_q;

  logic          accept_c;
  logic [DW:0]   in_ext_c;
  logic [DW:0]   old_ext_c;
  logic [DW:0]   diff_c;

  // A sample is taken only when no flush of any kind is requested this cycle.
  assign accept_c = valid_i & ~clear_i & ~srst_i;

  // Pointer wraps at N-1 (N need not be a power of two); fill count saturates at N.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    if (accept_c) begin
      ptr_d = (ptr_q == PW'(N - 1)) ? '0 : ptr_q + PW'(1);
      cnt_d = (cnt_q == CW'(N)) ? cnt_q : cnt_q + CW'(1);
    end
    full_d = (cnt_d == CW'(N));
  end

  always_ff @(posedge clk_i) begin
    if (srst_i || clear_i) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      v1_q    <= 1'b0;
      in1_q   <= '0;
      real1_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      v1_q    <= accept_c;
      if (accept_c) begin
        in1_q   <= data_i;
        real1_q <= (cnt_q == CW'(N));
      end
      valid_q <= v1_q;
    end
  end

  // Delay line: synchronous read of the old word, then overwrite at the same address.
  always_ff @(posedge clk_i) begin
    if (accept_c) begin
      old1_q     <= mem[ptr_q];
      mem[ptr_q] <= data_i;
    end
  end

  // Until the window is full the delayed sample is an implied zero; stale memory is ignored.
  always_comb begin
    in_ext_c  = {in1_q[DW-1], in1_q};
    old_ext_c = real1_q ? {old1_q[DW-1], old1_q} : '0;
    diff_c    = in_ext_c - old_ext_c;
  end

  // data_o holds between valid samples; only srst_i zeroes it, clear_i leaves it alone.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      data_q <= '0;
    end else if (v1_q && !clear_i) begin
      data_q <= diff_c;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign full_o  = full_q;

endmodule

// File: tb/tb_sdft_comb.sv
// Bench for sdft_comb: three window lengths driven in parallel and checked against a
// sample-history reference model every cycle.
module tb_sdft_comb;

  logic       clk = 1'b0;
  logic       srst;
  logic       valid;
  logic       clear;
  logic [7:0] din;

  logic [8:0] dout [3];
  logic       vout [3];
  logic       fout [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdft_comb #(.DW(8), .N(4)) u_n4 (
    .clk_i(clk), .srst_i(srst), .data_i(din), .valid_i(valid), .clear_i(clear),
    .data_o(dout[0]), .valid_o(vout[0]), .full_o(fout[0]));
  sdft_comb #(.DW(8), .N(2)) u_n2 (
    .clk_i(clk), .srst_i(srst), .data_i(din), .valid_i(valid), .clear_i(clear),
    .data_o(dout[1]), .valid_o(vout[1]), .full_o(fout[1]));
  sdft_comb #(.DW(8), .N(5)) u_n5 (
    .clk_i(clk), .srst_i(srst), .data_i(din), .valid_i(valid), .clear_i(clear),
    .data_o(dout[2]), .valid_o(vout[2]), .full_o(fout[2]));

  // Reference state: every accepted sample since the last flush, plus the 2-cycle latency.
  int nk [3] = '{4, 2, 5};
  int hist [3][4096];
  int n    [3];
  int s1v  [3];
  int s1d  [3];
  int ov   [3];
  int od   [3];
  int ef   [3];

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int d;
    d = int'($signed(din));
    for (int k = 0; k < 3; k++) begin
      if (srst || clear) begin
        n[k]   = 0;
        s1v[k] = 0;
        ov[k]  = 0;
        ef[k]  = 0;
        if (srst) od[k] = 0;
      end else begin
        ov[k] = s1v[k];
        if (s1v[k] != 0) od[k] = s1d[k];
        if (valid) begin
          s1d[k]     = d - ((n[k] >= nk[k]) ? hist[k][n[k] - nk[k]] : 0);
          hist[k][n[k]] = d;
          n[k]++;
          s1v[k]     = 1;
        end else begin
          s1v[k] = 0;
        end
        ef[k] = (n[k] >= nk[k]) ? 1 : 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("valid_n%0d", nk[k]), 32'(vout[k]), ov[k]);
      check($sformatf("full_n%0d", nk[k]), 32'(fout[k]), ef[k]);
      check($sformatf("data_n%0d", nk[k]), 32'($signed(dout[k])), od[k]);
    end
  endtask

  task automatic send(input int d);
    valid = 1'b1;
    din   = 8'(d);
    cycle();
    valid = 1'b0;
  endtask

  task automatic idle(input int c);
    valid = 1'b0;
    for (int i = 0; i < c; i++) cycle();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  task automatic fill_seq();
    for (int i = 1; i <= 6; i++) send(10 * i);
    idle(3);
  endtask

  initial begin
    srst  = 1'b1;
    valid = 1'b0;
    clear = 1'b0;
    din   = '0;
    for (int k = 0; k < 3; k++) begin
      n[k] = 0; s1v[k] = 0; s1d[k] = 0; ov[k] = 0; od[k] = 0; ef[k] = 0;
    end
    cycle();
    cycle();
    srst = 1'b0;

    fill_seq();

    pulse_clear();
    send(127); send(-128); send(-128); send(127);
    idle(3);

    pulse_clear();
    for (int i = 1; i <= 5; i++) begin
      send(i);
      idle(int'($urandom_range(0, 3)));
    end
    idle(3);

    pulse_clear();
    for (int i = 0; i < 20; i++) send(i);
    idle(3);

    pulse_clear();
    for (int i = 0; i < 8; i++) send(3 * i + 1);
    valid = 1'b1;
    clear = 1'b1;
    din   = 8'(99);
    cycle();
    clear = 1'b0;
    valid = 1'b0;
    send(-7); send(33); send(100);
    idle(3);

    for (int i = 0; i < 7; i++) send(int'($urandom_range(0, 255)) - 128);
    srst  = 1'b1;
    valid = 1'b1;
    din   = 8'(55);
    cycle();
    srst  = 1'b0;
    valid = 1'b0;
    fill_seq();

    for (int i = 0; i < 600; i++) begin
      valid = ($urandom % 3) != 0;
      din   = 8'($urandom);
      clear = ($urandom % 50) == 0;
      srst  = ($urandom % 150) == 0;
      cycle();
    end
    valid = 1'b0;
    clear = 1'b0;
    srst  = 1'b0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
